// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Load encodings, bundle widths, FSM state and packed zip layouts.
package mem_pkg;

  localparam int RF_ZIP_W  = 38;
  localparam int MEM_ZIP_W = 6;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FRESH = 2'd1,
    HELD  = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic       is_load;
    logic [2:0] ld_type;
    logic [1:0] addr_lo;
  } mem_zip_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] wdata;
  } rf_zip_t;

endpackage

// File: rtl/mem_stage_if.sv
// EX->MEM->WB handshake and data bus for the memory stage.
// slave is the stage itself; master is whatever drives EX/WB/SRAM.
interface mem_stage_if;
  import mem_pkg::*;

  logic                 mem_allowin;
  logic                 ex_to_mem_valid;
  logic [31:0]          ex_pc;
  logic [MEM_ZIP_W-1:0] ex_mem_zip;
  logic [RF_ZIP_W-1:0]  ex_rf_zip;
  logic [31:0]          data_sram_rdata;
  logic                 wb_allowin;
  logic                 mem_to_wb_valid;
  logic [31:0]          mem_pc;
  logic [RF_ZIP_W-1:0]  mem_rf_zip;
  logic [RF_ZIP_W-1:0]  mem_fwd_zip;

  modport slave (
    output mem_allowin,
    input  ex_to_mem_valid,
    input  ex_pc,
    input  ex_mem_zip,
    input  ex_rf_zip,
    input  data_sram_rdata,
    input  wb_allowin,
    output mem_to_wb_valid,
    output mem_pc,
    output mem_rf_zip,
    output mem_fwd_zip
  );

  modport master (
    input  mem_allowin,
    output ex_to_mem_valid,
    output ex_pc,
    output ex_mem_zip,
    output ex_rf_zip,
    output data_sram_rdata,
    output wb_allowin,
    input  mem_to_wb_valid,
    input  mem_pc,
    input  mem_rf_zip,
    input  mem_fwd_zip
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load data alignment: byte/half select by address, sign/zero extend.
// Reserved ld_type encodings fall through to a whole-word load.
module load_align
  import mem_pkg::*;
(
  input  logic [2:0]  ld_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  assign shifted = rdata >> {addr_lo, 3'b000};
  assign b       = shifted[7:0];
  assign h       = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    unique case (1'b1)
      (ld_type == LD_B):  result = {{24{b[7]}}, b};
      (ld_type == LD_H):  result = {{16{h[15]}}, h};
      (ld_type == LD_BU): result = {24'd0, b};
      (ld_type == LD_HU): result = {16'd0, h};
      default:            result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction between EX and WB and
// buffers the one-cycle SRAM read data while WB stalls.
module mem_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  bus
);

  mem_state_t  state, state_nxt;
  logic [31:0] pc_r;
  mem_zip_t    mem_zip_r;
  rf_zip_t     rf_zip_r;
  logic [31:0] rdata_buf;
  logic [31:0] rdata_sel;
  logic [31:0] ld_data;
  logic [31:0] final_wdata;
  logic        mem_valid;
  logic        accept;
  logic        advance;

  assign mem_valid = (state != EMPTY);
  assign accept    = bus.ex_to_mem_valid & bus.mem_allowin;
  assign advance   = mem_valid & bus.wb_allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= EMPTY;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (accept) state_nxt = FRESH;
      FRESH,
      HELD: begin
        if (advance) state_nxt = accept ? FRESH : EMPTY;
        else         state_nxt = HELD;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_r      <= '0;
      mem_zip_r <= '0;
      rf_zip_r  <= '0;
    end else if (accept) begin
      pc_r      <= bus.ex_pc;
      mem_zip_r <= bus.ex_mem_zip;
      rf_zip_r  <= bus.ex_rf_zip;
    end
  end

  // SRAM data only lives for the first MEM cycle; keep it on a stall
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      rdata_buf <= '0;
    else if (state == FRESH && !advance)
      rdata_buf <= bus.data_sram_rdata;
  end

  assign rdata_sel = (state == HELD) ? rdata_buf : bus.data_sram_rdata;

  load_align u_align (
    .ld_type (mem_zip_r.ld_type),
    .addr_lo (mem_zip_r.addr_lo),
    .rdata   (rdata_sel),
    .result  (ld_data)
  );

  assign final_wdata = mem_zip_r.is_load ? ld_data : rf_zip_r.wdata;

  assign bus.mem_allowin     = ~mem_valid | bus.wb_allowin;
  assign bus.mem_to_wb_valid = mem_valid;
  assign bus.mem_pc          = pc_r;
  assign bus.mem_rf_zip      = {rf_zip_r.rf_we, rf_zip_r.rf_waddr,
                                final_wdata};
  assign bus.mem_fwd_zip     = {rf_zip_r.rf_we & mem_valid,
                                rf_zip_r.rf_waddr, final_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, scoreboard
// monitor on the WB handshake, and stall/reset/bypass sequences.
module tb_mem_stage;
  import mem_pkg::*;

  logic clk;
  logic resetn;

  mem_stage_if bus ();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_load;
    logic [2:0]  ld;
    logic [1:0]  lo;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] exp;
  } vec_t;

  int          n_pass = 0;
  int          n_tot  = 0;
  logic [37:0] sb[$];
  logic [37:0] sb_e;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic drive(input logic ld_en, input logic [2:0] t,
                       input logic [1:0] lo, input logic [4:0] wa,
                       input logic [31:0] alu, input logic [31:0] pc,
                       input logic [31:0] exp);
    bus.ex_to_mem_valid = 1'b1;
    bus.ex_pc           = pc;
    bus.ex_mem_zip      = {ld_en, t, lo};
    bus.ex_rf_zip       = {1'b1, wa, alu};
    sb.push_back({1'b1, wa, exp});
  endtask

  // Scoreboard: every WB handshake pops one expected rf zip
  always @(negedge clk) begin
    if (resetn && bus.mem_to_wb_valid && bus.wb_allowin) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        sb_e = sb.pop_front();
        chk("wb_zip", {26'd0, bus.mem_rf_zip}, {26'd0, sb_e});
      end
    end
  end

  vec_t vt[11];
  logic [31:0] bb_rd[4];
  logic [31:0] bb_ex[4];

  initial begin
    vt[0]  = '{1, LD_B,   2'd2, 32'h12803456, 32'h0, 32'hFFFFFF80};
    vt[1]  = '{1, LD_BU,  2'd2, 32'h12803456, 32'h0, 32'h00000080};
    vt[2]  = '{1, LD_HU,  2'd2, 32'hBEEF0000, 32'h0, 32'h0000BEEF};
    vt[3]  = '{1, LD_H,   2'd2, 32'hBEEF0000, 32'h0, 32'hFFFFBEEF};
    vt[4]  = '{1, LD_W,   2'd3, 32'hBEEF0000, 32'h0, 32'hBEEF0000};
    vt[5]  = '{1, LD_B,   2'd0, 32'h000000FF, 32'h0, 32'hFFFFFFFF};
    vt[6]  = '{1, LD_HU,  2'd1, 32'h80001234, 32'h0, 32'h00001234};
    vt[7]  = '{1, 3'b011, 2'd1, 32'h11223344, 32'h0, 32'h11223344};
    vt[8]  = '{1, 3'b110, 2'd2, 32'h55667788, 32'h0, 32'h55667788};
    vt[9]  = '{0, LD_B,   2'd1, 32'hFFFFFFFF, 32'h2A, 32'h0000002A};
    vt[10] = '{1, LD_BU,  2'd3, 32'hAB000000, 32'h0, 32'h000000AB};

    resetn              = 1'b0;
    bus.ex_to_mem_valid = 1'b0;
    bus.ex_pc           = '0;
    bus.ex_mem_zip      = '0;
    bus.ex_rf_zip       = '0;
    bus.data_sram_rdata = '0;
    bus.wb_allowin      = 1'b1;

    #2;
    chk("rst_valid",   {63'd0, bus.mem_to_wb_valid}, 64'd0);
    chk("rst_allowin", {63'd0, bus.mem_allowin}, 64'd1);
    chk("rst_pc",      {32'd0, bus.mem_pc}, 64'd0);
    chk("rst_rf_zip",  {26'd0, bus.mem_rf_zip}, 64'd0);
    chk("rst_fwd_zip", {26'd0, bus.mem_fwd_zip}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Table: one load per two cycles, WB always ready
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      drive(vt[i].is_load, vt[i].ld, vt[i].lo, 5'(i + 1), vt[i].alu,
            32'h1000 + 32'(i * 4), vt[i].exp);
      @(posedge clk); #1;
      bus.ex_to_mem_valid = 1'b0;
      bus.data_sram_rdata = vt[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d_wdata", i), {32'd0, bus.mem_rf_zip[31:0]},
          {32'd0, vt[i].exp});
      chk($sformatf("vec%0d_pc", i), {32'd0, bus.mem_pc},
          {32'd0, 32'h1000 + 32'(i * 4)});
    end

    // Stall: data captured, immune to later SRAM changes
    @(posedge clk); #1;
    drive(1, LD_W, 2'd0, 5'd9, 32'h0, 32'h2000, 32'hCAFEF00D);
    @(posedge clk); #1;
    bus.ex_to_mem_valid = 1'b0;
    bus.data_sram_rdata = 32'hCAFEF00D;
    bus.wb_allowin      = 1'b0;
    @(negedge clk);
    chk("stall_c1_state", {62'd0, dut.state}, {62'd0, FRESH});
    chk("stall_c1_data", {32'd0, bus.mem_rf_zip[31:0]}, 64'hCAFEF00D);
    for (int c = 2; c <= 3; c++) begin
      @(posedge clk); #1;
      bus.data_sram_rdata = 32'hDEADBEEF;
      @(negedge clk);
      chk($sformatf("stall_c%0d_state", c), {62'd0, dut.state},
          {62'd0, HELD});
      chk($sformatf("stall_c%0d_data", c),
          {32'd0, bus.mem_rf_zip[31:0]}, 64'hCAFEF00D);
      chk($sformatf("stall_c%0d_allowin", c),
          {63'd0, bus.mem_allowin}, 64'd0);
      chk($sformatf("stall_c%0d_valid", c),
          {63'd0, bus.mem_to_wb_valid}, 64'd1);
    end
    @(posedge clk); #1;
    bus.wb_allowin = 1'b1;
    @(negedge clk);
    chk("release_allowin", {63'd0, bus.mem_allowin}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_empty", {62'd0, dut.state}, {62'd0, EMPTY});

    // Back-to-back loads, one per cycle, each with its own rdata
    bb_rd[0] = 32'h01020304; bb_ex[0] = 32'h00000003;
    bb_rd[1] = 32'hF0F0A5A5; bb_ex[1] = 32'hFFFFF0F0;
    bb_rd[2] = 32'h89ABCDEF; bb_ex[2] = 32'h89ABCDEF;
    bb_rd[3] = 32'h00FF7F00; bb_ex[3] = 32'h0000007F;
    @(posedge clk); #1;
    drive(1, LD_BU, 2'd1, 5'd20, 32'h0, 32'h3000, bb_ex[0]);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      bus.data_sram_rdata = bb_rd[k];
      if (k == 0) drive(1, LD_H, 2'd3, 5'd21, 32'h0, 32'h3004, bb_ex[1]);
      else if (k == 1)
        drive(1, LD_W, 2'd0, 5'd22, 32'h0, 32'h3008, bb_ex[2]);
      else if (k == 2)
        drive(1, LD_B, 2'd1, 5'd23, 32'h0, 32'h300C, bb_ex[3]);
      else bus.ex_to_mem_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("b2b%0d_state", k), {62'd0, dut.state},
          {62'd0, FRESH});
      chk($sformatf("b2b%0d_pc", k), {32'd0, bus.mem_pc},
          {32'd0, 32'h3000 + 32'(k * 4)});
    end

    // Async reset while HELD
    @(posedge clk); #1;
    drive(1, LD_W, 2'd0, 5'd3, 32'h0, 32'h4000, 32'h55AA55AA);
    @(posedge clk); #1;
    bus.ex_to_mem_valid = 1'b0;
    bus.data_sram_rdata = 32'h55AA55AA;
    bus.wb_allowin      = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_held", {62'd0, dut.state}, {62'd0, HELD});
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid",   {63'd0, bus.mem_to_wb_valid}, 64'd0);
    chk("arst_allowin", {63'd0, bus.mem_allowin}, 64'd1);
    chk("arst_pc",      {32'd0, bus.mem_pc}, 64'd0);
    chk("arst_rf_zip",  {26'd0, bus.mem_rf_zip}, 64'd0);
    chk("arst_fwd_zip", {26'd0, bus.mem_fwd_zip}, 64'd0);
    sb.delete();
    #2;
    resetn         = 1'b1;
    bus.wb_allowin = 1'b1;

    // Non-load bypass after reset release
    @(posedge clk); #1;
    drive(0, LD_W, 2'd0, 5'd7, 32'h0000002A, 32'h5000, 32'h0000002A);
    @(posedge clk); #1;
    bus.ex_to_mem_valid = 1'b0;
    bus.data_sram_rdata = 32'h12345678;
    @(negedge clk);
    chk("fwd_valid", {26'd0, bus.mem_fwd_zip},
        {26'd0, 1'b1, 5'd7, 32'h0000002A});
    chk("fwd_pc", {32'd0, bus.mem_pc}, 64'h5000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fwd_empty_we", {63'd0, bus.mem_fwd_zip[37]}, 64'd0);
    chk("empty_valid", {63'd0, bus.mem_to_wb_valid}, 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between EX and WB. Accepts an instruction from EX and takes the data SRAM read data that returns one cycle after EX issued the request. For loads, it aligns and sign- or zero-extends that data into the register write-back value, then hands `{rf_we, rf_waddr, rf_wdata}` to WB under a valid/allowin handshake. When WB stalls, it holds the SRAM read data in a local buffer, because the SRAM output is only valid for one cycle.

## Interface
Parameters: none. Widths are fixed by the shared package.
- `clk` in 1: the only clock; all state on the rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `mem_allowin` out 1: this stage can accept from EX this cycle.
- `ex_to_mem_valid` in 1: EX presents a valid instruction.
- `ex_pc` in 32: PC of the EX instruction.
- `ex_mem_zip` in 6: `{is_load, ld_type[2:0], addr_lo[1:0]}`.
- `ex_rf_zip` in 38: `{rf_we, rf_waddr[4:0], alu_result[31:0]}`.
- `data_sram_rdata` in 32: SRAM read data, valid in the first cycle the instruction sits in MEM.
- `wb_allowin` in 1: WB can accept.
- `mem_to_wb_valid` out 1: valid instruction offered to WB.
- `mem_pc` out 32: PC of the MEM instruction.
- `mem_rf_zip` out 38: `{rf_we, rf_waddr, final_wdata}`.
- `mem_fwd_zip` out 38: `{rf_we & mem_valid, rf_waddr, final_wdata}`, the bypass to ID.

## Operation
- State: `EMPTY`, `FRESH` (first cycle in MEM, SRAM data live) or `HELD` (SRAM data in the buffer). `mem_valid = (state != EMPTY)`.
- Handshake:
  - `ready_go = 1`.
  - `mem_allowin = ~mem_valid | wb_allowin`.
  - `mem_to_wb_valid = mem_valid`.
  - accept = `ex_to_mem_valid & mem_allowin`.
  - advance = `mem_valid & wb_allowin`.
- On accept, `pc_r`, `mem_zip_r` and `rf_zip_r` load the EX values. With no accept they keep their values.
- Transitions:
  - `EMPTY`: accept goes to `FRESH`, otherwise stay in `EMPTY`.
  - `FRESH`: advance with accept goes to `FRESH`; advance without accept goes to `EMPTY`; no advance goes to `HELD` and captures `data_sram_rdata` into `rdata_buf`.
  - `HELD`: advance with accept goes to `FRESH`; advance without accept goes to `EMPTY`; otherwise stay in `HELD`. `rdata_buf` is unchanged.
- Read-data source: `rdata_sel = (state==HELD) ? rdata_buf : data_sram_rdata`.
- Load formatting, applied when `is_load=1`:
  - `ld_type` 000 LD_B: sign-extend byte `addr_lo`.
  - 001 LD_H: sign-extend half selected by `addr_lo[1]`.
  - 010 LD_W: whole word, `addr_lo` ignored.
  - 100 LD_BU: zero-extend byte `addr_lo`.
  - 101 LD_HU: zero-extend half selected by `addr_lo[1]`.
  - Reserved encodings (011, 11x) behave as LD_W.
  - For halfwords, `addr_lo[0]` is ignored. Misalignment is trapped upstream.
- When `is_load=0`, `final_wdata = alu_result`. `data_sram_rdata` is ignored.
- `mem_rf_zip` carries `rf_we` unqualified. WB qualifies it with its own valid.

## Timing
- Latency: an instruction accepted at edge N is offered to WB during cycle N..N+1 and enters WB at the first edge with `wb_allowin=1`.
- `data_sram_rdata` → `mem_rf_zip`/`mem_fwd_zip` is combinational in `FRESH` and from a register in `HELD`.
- Reset assertion has immediate effect, asynchronous and mid-operation included:
  - state goes to `EMPTY`;
  - `pc_r`, `mem_zip_r`, `rf_zip_r` and `rdata_buf` clear to 0;
  - so `mem_to_wb_valid=0`, `mem_allowin=1`, `mem_pc=0`, `mem_rf_zip=0` and `mem_fwd_zip=0` without waiting for a clock edge.
- After reset deasserts, the first edge may accept.
- Simultaneous leave and enter in one cycle is a single transition into `FRESH`. The outgoing instruction reaches WB with the data it was showing.
- When stalled, outputs stay stable across cycles. In `HELD` they are immune to changes on `data_sram_rdata`.

## Structure
- Package `mem_pkg`:
  - `LD_B`, `LD_H`, `LD_W`, `LD_BU`, `LD_HU` codes;
  - `RF_ZIP_W=38`, `MEM_ZIP_W=6`;
  - the `mem_state_t` enum.
- Sub-module `load_align`: combinational; inputs `ld_type`, `addr_lo` and `rdata`; output 32-bit result.
- `mem_stage` holds the FSM, the pipeline registers and the buffer.

## Test plan
- LD_B, `addr_lo=2`, `rdata=0x12_80_34_56`, `wb_allowin=1` → WB receives `wdata=0xFFFFFF80`; LD_BU gives `0x00000080`.
- LD_HU, `addr_lo=2`, `rdata=0xBEEF0000` → `0x0000BEEF`; LD_H gives `0xFFFFBEEF`; LD_W, `addr_lo=3` → `0xBEEF0000`.
- LD_W (`rdata=0xCAFEF00D`, `wb_allowin=0` for 3 cycles), `rdata` forced to `0xDEADBEEF` from cycle 2 → state `HELD`; outputs stay `0xCAFEF00D` and `mem_allowin=0`; advance on release.
- Back-to-back loads with `wb_allowin=1` every cycle → one instruction per cycle; state stays `FRESH`; each uses its own cycle's `rdata`.
- Non-load `ex_rf_zip={1,5'd7,0x0000002A}` → `mem_fwd_zip={1,7,0x2A}` while valid; when `EMPTY`, `mem_fwd_zip[37]=0`.
- Assert `resetn=0` between edges while in `HELD` → `mem_to_wb_valid` drops at once and all outputs are 0; after release an accepted instruction proceeds normally.
